// File: rtl/cpa_chunked_x4.sv
// Chunk-serial carry-propagate adder. Operands are captured once, then one
// CHUNK-wide slice is resolved per clock with 4-bit carry-lookahead groups.
// The carry between slices is kept in a register.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for operands; an accepted pair starts a new addition
// RUN   | one chunk resolved per cycle, lowest chunk first
// DONE  | result valid and held until the consumer takes it
//
// WIDTH must be a multiple of CHUNK, and CHUNK a multiple of 4.
module cpa_chunked_x4 #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NGRP   = CHUNK / 4;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q;
  logic [IDXW-1:0]  idx_q;
  logic             last_chunk;

  logic [CHUNK-1:0] ch_a, ch_b, ch_p, ch_g, ch_sum;
  logic [NGRP:0]    grp_c;
  logic [3:0]       gp, gg, bc;

  assign last_chunk = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Resolve the current chunk: 4-bit lookahead groups, rippling group to group
  always_comb begin
    ch_a     = a_q[idx_q*CHUNK +: CHUNK];
    ch_b     = b_q[idx_q*CHUNK +: CHUNK];
    ch_p     = ch_a ^ ch_b;
    ch_g     = ch_a & ch_b;
    ch_sum   = '0;
    grp_c    = '0;
    gp       = '0;
    gg       = '0;
    bc       = '0;
    grp_c[0] = carry_q;
    for (int k = 0; k < NGRP; k++) begin
      gp    = ch_p[4*k +: 4];
      gg    = ch_g[4*k +: 4];
      bc[0] = grp_c[k];
      bc[1] = gg[0] | (gp[0] & grp_c[k]);
      bc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & grp_c[k]);
      bc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & grp_c[k]);
      ch_sum[4*k +: 4] = gp ^ bc;
      grp_c[k+1] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & grp_c[k]);
    end
  end

  // Operand capture, per-chunk result write-back and chunk carry register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
          end
        end
        RUN: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= ch_sum;
          carry_q <= grp_c[NGRP];
          // idx parks on the last chunk instead of wrapping
          if (last_chunk) cout_q <= grp_c[NGRP];
          else            idx_q  <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_cpa_chunked_x4.sv
module tb_cpa_chunked_x4;

  localparam int W  = 256;
  localparam int LW = W + 1;
  localparam logic [W-1:0] ONES  = '1;
  localparam logic [W-1:0] ZERO  = '0;
  localparam logic [W-1:0] FIVES = {64{4'h5}};
  localparam logic [W-1:0] AAAS  = {64{4'hA}};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         iv0 = 1'b0, iv1 = 1'b0;
  logic         ir0, ir1, ov0, ov1, co0, co1;
  logic         cin = 1'b0, ordy = 1'b0;
  logic [W-1:0] a = '0, b = '0, s0;
  logic [63:0]  s1;

  cpa_chunked_x4 u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
    .a(a), .b(b), .cin(cin), .out_valid(ov0), .out_ready(ordy),
    .sum(s0), .cout(co0)
  );

  cpa_chunked_x4 #(.WIDTH(64), .CHUNK(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a(a[63:0]), .b(b[63:0]), .cin(cin), .out_valid(ov1), .out_ready(ordy),
    .sum(s1), .cout(co1)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vt[13];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] res(input bit sel);
    return sel ? {co1, {(W-64){1'b0}}, s1} : {co0, s0};
  endfunction

  function automatic logic vld(input bit sel);
    return sel ? ov1 : ov0;
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? ir1 : ir0;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Entered and left on a falling edge.
  task automatic run_op(input bit sel, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic [LW-1:0] exp, input int lat,
                        input string name);
    int cycles;
    int stall;
    a = ta; b = tb; cin = tc;
    check({name, "/in_ready_idle"}, LW'(rdy(sel)), LW'(1));
    if (sel) iv1 = 1'b1; else iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0; iv1 = 1'b0;
    cycles = 0;
    while (!vld(sel) && cycles < 20) begin
      check({name, "/in_ready_run"}, LW'(rdy(sel)), LW'(0));
      a = rand_w(); b = rand_w(); cin = ~cin;
      @(negedge clk);
      cycles++;
    end
    check({name, "/latency"}, LW'(cycles), LW'(lat));
    check({name, "/result"}, res(sel), exp);
    check({name, "/in_ready_done"}, LW'(rdy(sel)), LW'(0));
    stall = $urandom_range(0, 3);
    for (int i = 0; i < stall; i++) begin
      ordy = 1'b0;
      @(negedge clk);
      check({name, "/stall_valid"}, LW'(vld(sel)), LW'(1));
      check({name, "/stall_hold"}, res(sel), exp);
    end
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    check({name, "/released_valid"}, LW'(vld(sel)), LW'(0));
    check({name, "/released_ready"}, LW'(rdy(sel)), LW'(1));
    n_vec++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [LW-1:0] exp;
    logic [64:0]  e64;

    vt[0]  = '{ONES, ZERO, 1'b1, ZERO, 1'b1};
    vt[1]  = '{W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, W'(1) << 64, 1'b0};
    vt[2]  = '{ZERO, ZERO, 1'b0, ZERO, 1'b0};
    vt[3]  = '{ZERO, ZERO, 1'b1, W'(1), 1'b0};
    vt[4]  = '{ONES, ONES, 1'b1, ONES, 1'b1};
    vt[5]  = '{ONES, ONES, 1'b0, ~W'(1), 1'b1};
    vt[6]  = '{W'(1) << 255, W'(1) << 255, 1'b0, ZERO, 1'b1};
    vt[7]  = '{W'({128{1'b1}}) << 64, W'(1) << 64, 1'b0, W'(1) << 192, 1'b0};
    vt[8]  = '{W'(8'h0F), W'(8'h01), 1'b0, W'(8'h10), 1'b0};
    vt[9]  = '{FIVES, AAAS, 1'b1, ZERO, 1'b1};
    vt[10] = '{FIVES, AAAS, 1'b0, ONES, 1'b0};
    vt[11] = '{W'(1) << 63, W'(1) << 63, 1'b0, W'(1) << 64, 1'b0};
    vt[12] = '{W'(1) << 191, W'(1) << 191, 1'b1, (W'(1) << 192) | W'(1), 1'b0};

    // Reset state
    #3 rst_n = 1'b0;
    @(negedge clk);
    check("reset/in_ready", LW'(ir0), LW'(1));
    check("reset/out_valid", LW'(ov0), LW'(0));
    check("reset/result", res(0), LW'(0));
    check("reset64/in_ready", LW'(ir1), LW'(1));

    // Release on a falling edge; the very next rising edge accepts
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++)
      run_op(0, vt[i].a, vt[i].b, vt[i].cin, {vt[i].cout, vt[i].sum}, 4, $sformatf("vec%0d", i));

    // Single-chunk instance
    run_op(1, W'(64'h8000_0000_0000_0000), W'(64'h8000_0000_0000_0000), 1'b0,
           {1'b1, ZERO}, 1, "w64_msb");
    run_op(1, W'(64'hFFFF_FFFF_FFFF_FFFF), ZERO, 1'b1, {1'b1, ZERO}, 1, "w64_ones");
    run_op(1, W'(5), W'(7), 1'b1, {1'b0, W'(13)}, 1, "w64_small");

    // in_valid held high across RUN/DONE while a changes: only the first pair counts
    a = ONES; b = ZERO; cin = 1'b1; iv0 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("hold/in_ready_busy", LW'(ir0), LW'(0));
      a = ZERO; cin = 1'b0;
      @(negedge clk);
    end
    check("hold/valid", LW'(ov0), LW'(1));
    check("hold/result", res(0), {1'b1, ZERO});
    check("hold/in_ready_done", LW'(ir0), LW'(0));
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    check("hold/back_idle", LW'(ir0), LW'(1));
    check("hold/valid_low", LW'(ov0), LW'(0));
    a = W'(8'h10); b = W'(8'h20);
    @(negedge clk);
    iv0 = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("hold/second_valid", LW'(ov0), LW'(1));
    check("hold/second_result", res(0), {1'b0, W'(8'h30)});
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    n_vec += 2;

    // Reset during RUN cycle 2
    a = ONES; b = ZERO; cin = 1'b1; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_run/out_valid", LW'(ov0), LW'(0));
    check("rst_run/in_ready", LW'(ir0), LW'(1));
    check("rst_run/result", res(0), LW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_run/no_result", LW'(ov0), LW'(0));
    end
    run_op(0, vt[1].a, vt[1].b, vt[1].cin, {vt[1].cout, vt[1].sum}, 4, "after_rst_run");

    // Reset while DONE
    a = ONES; b = ONES; cin = 1'b1; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("rst_done/pre_valid", LW'(ov0), LW'(1));
    rst_n = 1'b0;
    #1;
    check("rst_done/out_valid", LW'(ov0), LW'(0));
    check("rst_done/result", res(0), LW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, vt[8].a, vt[8].b, vt[8].cin, {vt[8].cout, vt[8].sum}, 4, "after_rst_done");

    // Random operands with random output stalls, against a plain full-width add
    for (int i = 0; i < 300; i++) begin
      ra = rand_w();
      rb = rand_w();
      rc = 1'($urandom_range(0, 1));
      if (i % 4 == 1) rb = ~ra;
      if (i % 4 == 2) ra = ONES ^ (W'(1) << $urandom_range(0, W-1));
      exp = {1'b0, ra} + {1'b0, rb} + LW'(rc);
      run_op(0, ra, rb, rc, exp, 4, "rand");
    end
    for (int i = 0; i < 50; i++) begin
      ra = rand_w();
      rb = rand_w();
      rc = 1'($urandom_range(0, 1));
      if (i % 3 == 1) rb = ~ra;
      e64 = {1'b0, ra[63:0]} + {1'b0, rb[63:0]} + 65'(rc);
      run_op(1, ra, rb, rc, {e64[64], {(W-64){1'b0}}, e64[63:0]}, 1, "rand64");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
